// File: rtl/l1_dram_arbiter.sv
// Two-port (I-cache / D-cache) line arbiter in front of a single DRAM port.
// Define L1_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; default gives the D-cache priority.
module l1_dram_arbiter #(
  parameter int unsigned addr_width     = 32,
  parameter int unsigned mem_data_width = 256
) (
  input  logic                      clk,
  input  logic                      rst,

  input  logic [addr_width-1:0]     p0_addr,
  input  logic                      p0_cs,
  input  logic                      p0_we,
  input  logic [mem_data_width-1:0] p0_data_i,
  output logic                      p0_ack,
  output logic [mem_data_width-1:0] p0_data_o,

  input  logic [addr_width-1:0]     p1_addr,
  input  logic                      p1_cs,
  input  logic                      p1_we,
  input  logic [mem_data_width-1:0] p1_data_i,
  output logic                      p1_ack,
  output logic [mem_data_width-1:0] p1_data_o,

  output logic [addr_width-1:0]     dram_addr,
  output logic                      dram_cs,
  output logic                      dram_we,
  input  logic                      dram_ack,
  input  logic [mem_data_width-1:0] dram_data_i,
  output logic [mem_data_width-1:0] dram_data_o,

  output logic                      owner
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]                state_q,  state_d;
  logic                      owner_q,  owner_d;
  logic [addr_width-1:0]     addr_q,   addr_d;
  logic                      we_q,     we_d;
  logic                      cs_q,     cs_d;
  logic [mem_data_width-1:0] wdata_q,  wdata_d;
  logic                      ack0_q,   ack0_d;
  logic                      ack1_q,   ack1_d;
  logic [mem_data_width-1:0] rdata0_q, rdata0_d;
  logic [mem_data_width-1:0] rdata1_q, rdata1_d;

  logic req0, req1;
  logic grant_vld;
  logic grant_port;
  logic tie_winner;

  // In DONE the just-served requester is still holding cs; mask it so the other port can go.
  always_comb begin
    req0 = p0_cs;
    req1 = p1_cs;
    if (state_q == ST_DONE) begin
      if (owner_q) req1 = 1'b0;
      else         req0 = 1'b0;
    end
  end

  always_comb begin
`ifdef L1_ARB_ROUND_ROBIN_EN
    tie_winner = ~owner_q;
`else
    tie_winner = 1'b1;
`endif
    grant_vld  = (state_q != ST_BUSY) && (req0 || req1);
    grant_port = (req0 && req1) ? tie_winner : req1;
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    addr_d   = addr_q;
    we_d     = we_q;
    cs_d     = cs_q;
    wdata_d  = wdata_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;

    case (state_q)
      ST_BUSY: begin
        if (dram_ack) begin
          state_d = ST_DONE;
          cs_d    = 1'b0;
          if (owner_q) begin
            ack1_d   = 1'b1;
            rdata1_d = dram_data_i;
          end else begin
            ack0_d   = 1'b0 | 1'b1;
            rdata0_d = dram_data_i;
          end
        end
      end
      default: begin
        // IDLE, DONE and the unused encoding all arbitrate; dram_ack is ignored here.
        if (grant_vld) begin
          state_d = ST_BUSY;
          cs_d    = 1'b1;
          owner_d = grant_port;
          if (grant_port) begin
            addr_d  = p1_addr;
            we_d    = p1_we;
            wdata_d = p1_data_i;
          end else begin
            addr_d  = p0_addr;
            we_d    = p0_we;
            wdata_d = p0_data_i;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      owner_q  <= 1'b0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      cs_q     <= 1'b0;
      wdata_q  <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      cs_q     <= cs_d;
      wdata_q  <= wdata_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign dram_addr   = addr_q;
  assign dram_cs     = cs_q;
  assign dram_we     = we_q;
  assign dram_data_o = wdata_q;
  assign owner       = owner_q;
  assign p0_ack      = ack0_q;
  assign p1_ack      = ack1_q;
  assign p0_data_o   = rdata0_q;
  assign p1_data_o   = rdata1_q;

endmodule

// File: tb/tb_l1_dram_arbiter.sv
// Self-checking bench for l1_dram_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of the arbitration rules.
module tb_l1_dram_arbiter;
  localparam int AW = 32;
  localparam int DW = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] p0_addr = '0, p1_addr = '0;
  logic          p0_cs = 1'b0, p1_cs = 1'b0, p0_we = 1'b0, p1_we = 1'b0;
  logic [DW-1:0] p0_data_i = '0, p1_data_i = '0;
  logic          p0_ack, p1_ack;
  logic [DW-1:0] p0_data_o, p1_data_o;
  logic [AW-1:0] dram_addr;
  logic          dram_cs, dram_we;
  logic          dram_ack = 1'b0;
  logic [DW-1:0] dram_data_i = '0;
  logic [DW-1:0] dram_data_o;
  logic          owner;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: who was granted last, and the last fill data each port received.
  logic          model_owner;
  logic [DW-1:0] last_d [2];

  logic [1:0]    acks;
  logic [DW-1:0] pdo [2];
  assign acks   = {p1_ack, p0_ack};
  assign pdo[0] = p0_data_o;
  assign pdo[1] = p1_data_o;

  always #5 clk = ~clk;

  l1_dram_arbiter #(.addr_width(AW), .mem_data_width(DW)) dut (
    .clk(clk), .rst(rst),
    .p0_addr(p0_addr), .p0_cs(p0_cs), .p0_we(p0_we), .p0_data_i(p0_data_i),
    .p0_ack(p0_ack), .p0_data_o(p0_data_o),
    .p1_addr(p1_addr), .p1_cs(p1_cs), .p1_we(p1_we), .p1_data_i(p1_data_i),
    .p1_ack(p1_ack), .p1_data_o(p1_data_o),
    .dram_addr(dram_addr), .dram_cs(dram_cs), .dram_we(dram_we),
    .dram_ack(dram_ack), .dram_data_i(dram_data_i), .dram_data_o(dram_data_o),
    .owner(owner)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rnd_line();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic tie_winner(input logic last_owner);
`ifdef L1_ARB_ROUND_ROBIN_EN
    return ~last_owner;
`else
    return 1'b1;
`endif
  endfunction

  task automatic dram_pulse(input logic [DW-1:0] d);
    dram_ack = 1'b1;
    dram_data_i = d;
    tick();
    dram_ack = 1'b0;
    dram_data_i = rnd_line();
  endtask

  task automatic test_reset();
    rst = 1'b0; p0_cs = 1'b0; p1_cs = 1'b0; dram_ack = 1'b0;
    tick(); tick();
    n_cmp++;
    if ({dram_cs, dram_we, p0_ack, p1_ack, owner} !== 5'b0) begin
      n_bad++; $display("FAIL reset_ctrl: got %b want 00000", {dram_cs, dram_we, p0_ack, p1_ack, owner});
    end
    n_cmp++;
    if (dram_addr !== '0) begin n_bad++; $display("FAIL reset_addr: got %h want 0", dram_addr); end
    n_cmp++;
    if (dram_data_o !== '0) begin n_bad++; $display("FAIL reset_wdata: got %h want 0", dram_data_o); end
    n_cmp++;
    if (p0_data_o !== '0 || p1_data_o !== '0) begin
      n_bad++; $display("FAIL reset_rdata: got %h / %h want 0", p0_data_o, p1_data_o);
    end
    rst = 1'b1;
    model_owner = 1'b0;
    last_d[0] = '0;
    last_d[1] = '0;
  endtask

  task automatic test_single_fill();
    logic [DW-1:0] a5;
    a5 = {32{8'hA5}};
    p0_addr = 32'h0000_1000; p0_we = 1'b0; p0_data_i = rnd_line(); p0_cs = 1'b1;
    for (int k = 0; k < 8 && dram_cs !== 1'b1; k++) tick();
    n_cmp++;
    if (dram_cs !== 1'b1) begin n_bad++; $display("FAIL fill_cs: got %b want 1", dram_cs); end
    n_cmp++;
    if (dram_addr !== 32'h1000 || dram_we !== 1'b0 || owner !== 1'b0) begin
      n_bad++; $display("FAIL fill_latch: got addr %h we %b owner %b want 1000 0 0", dram_addr, dram_we, owner);
    end
    tick(); tick();
    n_cmp++;
    if (dram_cs !== 1'b1 || acks !== 2'b00) begin
      n_bad++; $display("FAIL fill_wait: got cs %b acks %b want 1 00", dram_cs, acks);
    end
    dram_pulse(a5);
    n_cmp++;
    if (p0_ack !== 1'b1 || p0_data_o !== a5 || p1_ack !== 1'b0 || dram_cs !== 1'b0) begin
      n_bad++; $display("FAIL fill_ack: got ack %b%b cs %b data %h want 01 0 %h", p1_ack, p0_ack, dram_cs, p0_data_o, a5);
    end
    p0_cs = 1'b0;
    tick();
    n_cmp++;
    if (acks !== 2'b00 || p0_data_o !== a5 || dram_cs !== 1'b0) begin
      n_bad++; $display("FAIL fill_after: got acks %b cs %b data %h want 00 0 %h", acks, dram_cs, p0_data_o, a5);
    end
    model_owner = 1'b0;
    last_d[0] = a5;
  endtask

  // Both ports hold cs continuously and re-issue right after their ack: grants must alternate.
  task automatic test_back_to_back();
    logic          exp;
    logic [AW-1:0] a [2];
    logic [DW-1:0] d;
    a[0] = $urandom; a[1] = $urandom;
    p0_addr = a[0]; p1_addr = a[1]; p0_we = 1'b0; p1_we = 1'b1;
    p0_cs = 1'b1; p1_cs = 1'b1;
    exp = tie_winner(model_owner);
    for (int t = 0; t < 4; t++) begin
      for (int k = 0; k < 8 && dram_cs !== 1'b1; k++) tick();
      n_cmp++;
      if (dram_cs !== 1'b1 || owner !== exp || dram_addr !== a[exp]) begin
        n_bad++; $display("FAIL b2b_grant%0d: got cs %b owner %b addr %h want 1 %b %h", t, dram_cs, owner, dram_addr, exp, a[exp]);
      end
      repeat ($urandom_range(0, 3)) tick();
      d = rnd_line();
      dram_pulse(d);
      n_cmp++;
      if (acks[exp] !== 1'b1 || acks[~exp] !== 1'b0 || pdo[exp] !== d || pdo[~exp] !== last_d[~exp]) begin
        n_bad++; $display("FAIL b2b_ack%0d: got acks %b want port %b only", t, acks, exp);
      end
      last_d[exp] = d;
      model_owner = exp;
      a[exp] = $urandom;
      if (exp) p1_addr = a[1]; else p0_addr = a[0];
      if (t == 3) begin p0_cs = 1'b0; p1_cs = 1'b0; end
      exp = ~exp;
    end
    tick();
    n_cmp++;
    if (dram_cs !== 1'b0 || acks !== 2'b00) begin
      n_bad++; $display("FAIL b2b_idle: got cs %b acks %b want 0 00", dram_cs, acks);
    end
  endtask

  task automatic test_reset_mid_busy();
    logic [AW-1:0] a;
    logic [DW-1:0] wd, d;
    a = $urandom;
    wd = {16{16'h1234}};
    p1_addr = a; p1_we = 1'b1; p1_data_i = wd; p1_cs = 1'b1;
    for (int k = 0; k < 8 && dram_cs !== 1'b1; k++) tick();
    tick();
    rst = 1'b0;
    tick();
    n_cmp++;
    if (dram_cs !== 1'b0 || p1_ack !== 1'b0 || owner !== 1'b0 || dram_addr !== '0) begin
      n_bad++; $display("FAIL rstbusy_abort: got cs %b ack %b owner %b addr %h want 0 0 0 0", dram_cs, p1_ack, owner, dram_addr);
    end
    rst = 1'b1;
    model_owner = 1'b0;
    last_d[0] = '0; last_d[1] = '0;
    tick();
    n_cmp++;
    if (dram_cs !== 1'b1 || owner !== 1'b1 || dram_addr !== a || dram_we !== 1'b1 || dram_data_o !== wd || acks !== 2'b00) begin
      n_bad++; $display("FAIL rstbusy_regrant: got cs %b owner %b addr %h we %b acks %b want 1 1 %h 1 00", dram_cs, owner, dram_addr, dram_we, acks, a);
    end
    d = rnd_line();
    dram_pulse(d);
    n_cmp++;
    if (p1_ack !== 1'b1 || p1_data_o !== d || p0_ack !== 1'b0) begin
      n_bad++; $display("FAIL rstbusy_ack: got acks %b data %h want 10 %h", acks, p1_data_o, d);
    end
    p1_cs = 1'b0;
    model_owner = 1'b1;
    last_d[1] = d;
    tick();
  endtask

  task automatic test_spurious_and_drop();
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    dram_pulse(rnd_line());
    n_cmp++;
    if (acks !== 2'b00 || p0_data_o !== last_d[0] || p1_data_o !== last_d[1] || dram_cs !== 1'b0) begin
      n_bad++; $display("FAIL spur_idle: got acks %b cs %b want 00 0", acks, dram_cs);
    end
    a = $urandom;
    p0_addr = a; p0_we = 1'b1; p0_data_i = rnd_line(); p0_cs = 1'b1;
    for (int k = 0; k < 8 && dram_cs !== 1'b1; k++) tick();
    p0_cs = 1'b0;
    tick();
    n_cmp++;
    if (dram_cs !== 1'b1 || dram_addr !== a || acks !== 2'b00) begin
      n_bad++; $display("FAIL drop_busy: got cs %b addr %h acks %b want 1 %h 00", dram_cs, dram_addr, acks, a);
    end
    tick();
    d = rnd_line();
    dram_ack = 1'b1; dram_data_i = d;
    tick();
    n_cmp++;
    if (p0_ack !== 1'b1 || p0_data_o !== d || p1_ack !== 1'b0) begin
      n_bad++; $display("FAIL drop_ack: got acks %b data %h want 01 %h", acks, p0_data_o, d);
    end
    dram_data_i = rnd_line();
    tick();
    dram_ack = 1'b0;
    n_cmp++;
    if (acks !== 2'b00 || p0_data_o !== d || dram_cs !== 1'b0) begin
      n_bad++; $display("FAIL spur_done: got acks %b cs %b data %h want 00 0 %h", acks, dram_cs, p0_data_o, d);
    end
    tick();
    n_cmp++;
    if (acks !== 2'b00 || dram_cs !== 1'b0) begin
      n_bad++; $display("FAIL drop_single: got acks %b cs %b want 00 0", acks, dram_cs);
    end
    model_owner = 1'b0;
    last_d[0] = d;
  endtask

  task automatic test_random();
    logic [1:0]    mask;
    logic [AW-1:0] a [2];
    logic          w [2];
    logic [DW-1:0] wd [2];
    logic [DW-1:0] d;
    logic          cur;
    int            nsrv, lat;
    for (int it = 0; it < 40; it++) begin
      mask = 2'($urandom_range(1, 3));
      for (int p = 0; p < 2; p++) begin
        a[p] = $urandom; w[p] = 1'($urandom); wd[p] = rnd_line();
      end
      p0_addr = a[0]; p0_we = w[0]; p0_data_i = wd[0];
      p1_addr = a[1]; p1_we = w[1]; p1_data_i = wd[1];
      p0_cs = mask[0]; p1_cs = mask[1];
      cur  = (mask == 2'b11) ? tie_winner(model_owner) : mask[1];
      nsrv = (mask == 2'b11) ? 2 : 1;
      for (int s = 0; s < nsrv; s++) begin
        for (int k = 0; k < 8 && dram_cs !== 1'b1; k++) tick();
        n_cmp++;
        if (dram_cs !== 1'b1 || owner !== cur || dram_addr !== a[cur] || dram_we !== w[cur] || dram_data_o !== wd[cur]) begin
          n_bad++; $display("FAIL rnd_grant it%0d: got cs %b owner %b addr %h we %b want 1 %b %h %b", it, dram_cs, owner, dram_addr, dram_we, cur, a[cur], w[cur]);
        end
        lat = $urandom_range(1, 5);
        for (int k = 0; k < lat - 1; k++) begin
          if ($urandom_range(0, 3) == 0) begin
            if (cur) p1_cs = 1'b0; else p0_cs = 1'b0;
          end
          tick();
          n_cmp++;
          if (dram_cs !== 1'b1 || acks !== 2'b00 || dram_addr !== a[cur]) begin
            n_bad++; $display("FAIL rnd_busy it%0d: got cs %b acks %b addr %h want 1 00 %h", it, dram_cs, acks, dram_addr, a[cur]);
          end
        end
        d = rnd_line();
        dram_pulse(d);
        n_cmp++;
        if (acks[cur] !== 1'b1 || acks[~cur] !== 1'b0 || pdo[cur] !== d || pdo[~cur] !== last_d[~cur] || dram_cs !== 1'b0) begin
          n_bad++; $display("FAIL rnd_ack it%0d: got acks %b cs %b want port %b only", it, acks, dram_cs, cur);
        end
        if (cur) p1_cs = 1'b0; else p0_cs = 1'b0;
        last_d[cur] = d;
        model_owner = cur;
        cur = ~cur;
      end
      tick();
      n_cmp++;
      if (dram_cs !== 1'b0 || acks !== 2'b00) begin
        n_bad++; $display("FAIL rnd_idle it%0d: got cs %b acks %b want 0 00", it, dram_cs, acks);
      end
      if ($urandom_range(0, 1) == 1) begin
        dram_pulse(rnd_line());
        n_cmp++;
        if (acks !== 2'b00 || dram_cs !== 1'b0 || p0_data_o !== last_d[0] || p1_data_o !== last_d[1]) begin
          n_bad++; $display("FAIL rnd_spur it%0d: got acks %b cs %b want 00 0", it, acks, dram_cs);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single_fill();
    test_back_to_back();
    test_reset_mid_busy();
    test_spurious_and_drop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
